// File: rtl/sb_cfg_loader.sv
// sb_cfg_loader: streams bitstream words serially into a switch-block config chain
// and captures the bits shifted out of the chain tail as readback words. rev 1.0
`default_nettype none
`timescale 1ns/1ps

module sb_cfg_loader #(
  parameter int CHAIN_LEN = 24,
  parameter int WORD_W    = 8,
  parameter int CNT_W     = 16
) (
  input  logic              prog_clk,
  input  logic              prog_reset_n,
  input  logic              start,
  input  logic              abort,
  input  logic              s_valid,
  input  logic [WORD_W-1:0] s_data,
  output logic              s_ready,
  output logic              ccff_head,
  output logic              chain_clk_en,
  input  logic              ccff_tail,
  output logic              rb_valid,
  output logic [WORD_W-1:0] rb_data,
  output logic              busy,
  output logic              done
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] LOAD  = 2'd1;
  localparam logic [1:0] SHIFT = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  localparam int IDX_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CHAIN_LEN - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORD_W - 1);

  logic [1:0]        state;
  logic [WORD_W-1:0] shift_buf;
  logic [CNT_W-1:0]  bit_cnt;
  logic [IDX_W-1:0]  bit_idx;

  always_ff @(posedge prog_clk or negedge prog_reset_n) begin
    if (!prog_reset_n) begin
      state        <= IDLE;
      shift_buf    <= '0;
      bit_cnt      <= '0;
      bit_idx      <= '0;
      ccff_head    <= 1'b0;
      chain_clk_en <= 1'b0;
      rb_valid     <= 1'b0;
      rb_data      <= '0;
    end else begin
      rb_valid <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start && !abort) begin
            state   <= LOAD;
            bit_cnt <= '0;
          end
        end
        LOAD: begin
          if (abort) begin
            state <= IDLE;
          end else if (s_valid) begin
            // Bit 0 goes straight to the head register so the chain shifts it on the first enabled edge.
            state        <= SHIFT;
            ccff_head    <= s_data[0];
            shift_buf    <= s_data >> 1;
            chain_clk_en <= 1'b1;
            bit_idx      <= '0;
            rb_data      <= '0;
          end
        end
        SHIFT: begin
          // The gated chain edge coincides with this edge, so the tail bit being shifted out is taken here.
          rb_data[bit_idx] <= ccff_tail;
          bit_cnt          <= bit_cnt + CNT_W'(1);
          if (abort) begin
            state        <= IDLE;
            chain_clk_en <= 1'b0;
          end else if (bit_cnt == LAST_CNT || bit_idx == LAST_IDX) begin
            state        <= (bit_cnt == LAST_CNT) ? DONE : LOAD;
            chain_clk_en <= 1'b0;
            rb_valid     <= 1'b1;
          end else begin
            ccff_head <= shift_buf[0];
            shift_buf <= shift_buf >> 1;
            bit_idx   <= bit_idx + IDX_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign s_ready = (state == LOAD);
  assign busy    = (state == LOAD) || (state == SHIFT);
  assign done    = (state == DONE);

endmodule

`default_nettype wire

// File: tb/tb_sb_cfg_loader.sv
// tb_sb_cfg_loader: drives a 24-bit and a 20-bit loader, each with a behavioural chain,
// and compares head stream, run structure and readback against a queue model. rev 1.0
`default_nettype none
`timescale 1ns/1ps

module tb_sb_cfg_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, start, abort, s_valid;
  logic [7:0] s_data;
  bit         sel;

  logic start_a, abort_a, valid_a, start_b, abort_b, valid_b;
  assign start_a = start && !sel;
  assign abort_a = abort && !sel;
  assign valid_a = s_valid && !sel;
  assign start_b = start && sel;
  assign abort_b = abort && sel;
  assign valid_b = s_valid && sel;

  logic       ready_a, head_a, en_a, tail_a, rbv_a, busy_a, done_a;
  logic [7:0] rbd_a;
  logic       ready_b, head_b, en_b, tail_b, rbv_b, busy_b, done_b;
  logic [7:0] rbd_b;

  sb_cfg_loader #(.CHAIN_LEN(24), .WORD_W(8), .CNT_W(16)) dut_a (
    .prog_clk(clk), .prog_reset_n(rst_n), .start(start_a), .abort(abort_a),
    .s_valid(valid_a), .s_data(s_data), .s_ready(ready_a), .ccff_head(head_a),
    .chain_clk_en(en_a), .ccff_tail(tail_a), .rb_valid(rbv_a), .rb_data(rbd_a),
    .busy(busy_a), .done(done_a));

  sb_cfg_loader #(.CHAIN_LEN(20), .WORD_W(8), .CNT_W(16)) dut_b (
    .prog_clk(clk), .prog_reset_n(rst_n), .start(start_b), .abort(abort_b),
    .s_valid(valid_b), .s_data(s_data), .s_ready(ready_b), .ccff_head(head_b),
    .chain_clk_en(en_b), .ccff_tail(tail_b), .rb_valid(rbv_b), .rb_data(rbd_b),
    .busy(busy_b), .done(done_b));

  // Physical chains: shift only on gated edges, never reset.
  logic [23:0] chain_a = '0;
  logic [19:0] chain_b = '0;
  always @(posedge clk) if (en_a) chain_a <= {chain_a[22:0], head_a};
  always @(posedge clk) if (en_b) chain_b <= {chain_b[18:0], head_b};
  assign tail_a = chain_a[23];
  assign tail_b = chain_b[19];

  logic       ready_m, head_m, en_m, rbv_m, busy_m, done_m;
  logic [7:0] rbd_m;
  assign ready_m = sel ? ready_b : ready_a;
  assign head_m  = sel ? head_b  : head_a;
  assign en_m    = sel ? en_b    : en_a;
  assign rbv_m   = sel ? rbv_b   : rbv_a;
  assign busy_m  = sel ? busy_b  : busy_a;
  assign done_m  = sel ? done_b  : done_a;
  assign rbd_m   = sel ? rbd_b   : rbd_a;

  int checks = 0;
  int failures = 0;

  bit         cap_head[$];
  int         runs[$];
  logic [7:0] cap_rb[$];
  int         loads_before, en_cycles, ready_cycles;
  bit         last_en, last_ready;

  bit          refq[$];
  logic [7:0]  exp_rb[$];
  logic [7:0]  w[8];
  int          cur_len = 24;
  logic [31:0] last_head_vec;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One clock: values seen before the edge decide whether the chain shifted on it.
  task automatic tick();
    bit pe, ph, pr;
    pe = en_m; ph = head_m; pr = ready_m;
    @(posedge clk);
    #1;
    if (pe) begin
      cap_head.push_back(ph);
      en_cycles++;
      if (!last_en) begin
        runs.push_back(0);
        if (last_ready) loads_before++;
      end
      runs[runs.size()-1] = runs[runs.size()-1] + 1;
    end
    if (pr) ready_cycles++;
    if (rbv_m) cap_rb.push_back(rbd_m);
    last_en = pe;
    last_ready = pr;
  endtask

  task automatic clear_caps();
    cap_head.delete(); runs.delete(); cap_rb.delete();
    loads_before = 0; en_cycles = 0; ready_cycles = 0;
    last_en = en_m; last_ready = ready_m;
  endtask

  // Model: the first n stream bits enter the chain; tail bits leave in FIFO order and
  // are grouped into readback words at each word boundary and at the chain end.
  task automatic model_shift(input int n);
    logic [7:0] word;
    bit o;
    word = '0;
    exp_rb.delete();
    for (int j = 0; j < n; j++) begin
      o = refq.pop_front();
      refq.push_back(w[j/8][j%8]);
      word[j%8] = o;
      if (j % 8 == 7 || j == cur_len - 1) begin
        exp_rb.push_back(word);
        word = '0;
      end
    end
  endtask

  task automatic check_rb();
    check("rb_count", cap_rb.size(), exp_rb.size());
    for (int i = 0; i < exp_rb.size(); i++) check("rb_word", cap_rb[i], exp_rb[i]);
  endtask

  task automatic reset_ref(input int len);
    refq.delete();
    for (int i = 0; i < len; i++) refq.push_back(1'b0);
  endtask

  task automatic do_load(input int nw, input int stall_word, input int stall_len,
                         input int stop_at, output bit stopped);
    int guard;
    stopped = 0;
    start = 1; tick(); start = 0;
    for (int i = 0; i < nw; i++) begin
      guard = 0;
      while (!ready_m && guard < 40 && !stopped) begin
        tick(); guard++;
        if (cap_head.size() == stop_at) stopped = 1;
      end
      if (stopped) break;
      if (!ready_m) begin check("ready_timeout", ready_m, 1); break; end
      if (i == stall_word) repeat (stall_len) tick();
      s_data = w[i]; s_valid = 1; tick(); s_valid = 0;
      if (cap_head.size() == stop_at) begin stopped = 1; break; end
    end
    guard = 0;
    while (!stopped && !done_m && guard < 40) begin
      tick(); guard++;
      if (cap_head.size() == stop_at) stopped = 1;
    end
  endtask

  task automatic check_load(input int extra_ready);
    int nw;
    logic [31:0] ev, cv;
    nw = (cur_len + 7) / 8;
    ev = '0; cv = '0;
    for (int j = 0; j < cur_len; j++) ev[j] = w[j/8][j%8];
    for (int j = 0; j < cap_head.size() && j < 32; j++) cv[j] = cap_head[j];
    last_head_vec = cv;
    check("head_count", cap_head.size(), cur_len);
    check("head_seq", cv, ev);
    check("run_count", runs.size(), nw);
    for (int i = 0; i < runs.size(); i++)
      check("run_len", runs[i], (i == nw - 1) ? cur_len - 8 * (nw - 1) : 8);
    check("load_before_run", loads_before, nw);
    check("load_cycles", ready_cycles, nw + extra_ready);
    check("done_state", {done_m, busy_m, en_m, ready_m}, 4'b1000);
    model_shift(cur_len);
    check_rb();
  endtask

  task automatic rand_words();
    for (int i = 0; i < 8; i++) w[i] = 8'($urandom);
  endtask

  initial begin
    bit st;
    logic [7:0] tmp;
    int sw, sl;
    rst_n = 0; start = 0; abort = 0; s_valid = 0; s_data = '0; sel = 0;
    reset_ref(24);
    repeat (3) @(posedge clk);
    #1;
    check("reset_ctrl_a", {ready_a, en_a, head_a, rbv_a, busy_a, done_a}, 0);
    check("reset_rb_a", rbd_a, 0);
    check("reset_ctrl_b", {ready_b, en_b, head_b, rbv_b, busy_b, done_b}, 0);
    check("reset_rb_b", rbd_b, 0);
    rst_n = 1;
    clear_caps();
    repeat (3) tick();
    check("no_autostart", {busy_a, en_a, ready_a, done_a, 1'(cap_head.size() != 0)}, 0);

    // Directed load and readback through the 24-stage chain
    w[0] = 8'hA5; w[1] = 8'h3C; w[2] = 8'hF0;
    clear_caps(); do_load(3, -1, 0, -1, st); check_load(0);
    check("head_literal", last_head_vec, 32'h00F03CA5);
    w[0] = 8'h00; w[1] = 8'h00; w[2] = 8'h00;
    clear_caps(); do_load(3, -1, 0, -1, st); check_load(0);
    tmp = cap_rb[0]; check("rb_lit0", tmp, 8'hA5);
    tmp = cap_rb[1]; check("rb_lit1", tmp, 8'h3C);
    tmp = cap_rb[2]; check("rb_lit2", tmp, 8'hF0);

    // Five-cycle bubble before the second word
    rand_words();
    clear_caps(); do_load(3, 1, 5, -1, st); check_load(5);
    check("stall_en_total", en_cycles, 24);

    // Abort with 10 bits shifted
    rand_words();
    clear_caps(); do_load(3, -1, 0, 9, st);
    check("abort_reached", st, 1);
    abort = 1; tick(); abort = 0;
    check("abort_state", {done_m, busy_m, en_m, ready_m}, 0);
    repeat (4) tick();
    check("abort_shifts", cap_head.size(), 10);
    check("abort_quiet", {busy_m, en_m, done_m}, 0);
    model_shift(10); check_rb();

    // Abort wins over a simultaneous valid word
    clear_caps();
    start = 1; tick(); start = 0;
    s_valid = 1; abort = 1; s_data = 8'($urandom); tick();
    s_valid = 0; abort = 0; tick();
    check("abort_vs_valid", {busy_m, en_m, 1'(cap_head.size() != 0)}, 0);

    rand_words();
    clear_caps(); do_load(3, -1, 0, -1, st); check_load(0);

    // Asynchronous reset with 12 bits shifted; start held during reset
    rand_words();
    clear_caps(); do_load(3, -1, 0, 12, st);
    check("reset_reached", st, 1);
    #2 rst_n = 0;
    #1;
    check("midreset_ctrl", {ready_m, en_m, head_m, rbv_m, busy_m, done_m}, 0);
    check("midreset_rb", rbd_m, 0);
    start = 1; repeat (2) tick(); start = 0;
    #3 rst_n = 1;
    repeat (3) tick();
    check("reset_no_start", {busy_m, en_m, ready_m, done_m}, 0);
    check("reset_shifts", cap_head.size(), 12);
    model_shift(12); check_rb();

    rand_words();
    clear_caps(); do_load(3, -1, 0, -1, st); check_load(0);

    // Randomized loads with random bubbles
    for (int k = 0; k < 4; k++) begin
      rand_words();
      sw = $urandom_range(0, 2);
      sl = $urandom_range(0, 4);
      clear_caps(); do_load(3, sw, sl, -1, st); check_load(sl);
    end

    // 20-bit chain: partial last word
    sel = 1; cur_len = 20; reset_ref(20);
    w[0] = 8'hA5; w[1] = 8'h3C; w[2] = 8'hF0;
    clear_caps(); do_load(3, -1, 0, -1, st); check_load(0);
    rand_words(); w[2] = w[2] | 8'hF0;
    clear_caps(); do_load(3, -1, 0, -1, st); check_load(0);
    tmp = cap_rb[2]; check("partial_rb_upper", tmp & 8'hF0, 0);
    clear_caps();
    s_valid = 1; s_data = 8'($urandom); repeat (3) tick(); s_valid = 0;
    check("no_extra_word", {1'(cap_head.size() != 0), ready_m, done_m}, 3'b001);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/sb_cfg_loader.md
SB_CFG_LOADER -- requirements
Module: sb_cfg_loader

Interface
REQ-001 Parameter CHAIN_LEN, default 24: number of configuration-chain flip-flops between ccff_head and ccff_tail of the attached switch block.
REQ-002 Parameter WORD_W, default 8: width of the bitstream input word and of the readback word.
REQ-003 Parameter CNT_W, default 16: width of the bit counter; CHAIN_LEN SHALL be at most 2**CNT_W-1.
REQ-004 prog_clk  input  1  programming clock; the only clock of the block.
REQ-005 prog_reset_n  input  1  asynchronous, active-low reset.
REQ-006 start  input  1  one-cycle pulse that begins a chain load.
REQ-007 abort  input  1  level or pulse that cancels the load in progress.
REQ-008 s_valid  input  1  bitstream word valid.
REQ-009 s_data  input  WORD_W  bitstream word; bit 0 is shifted first.
REQ-010 s_ready  output  1  block can accept s_data.
REQ-011 ccff_head  output  1  serial data into the chain head.
REQ-012 chain_clk_en  output  1  enable for the external prog_clk gate of the chain; the chain shifts only on edges where this is 1.
REQ-013 ccff_tail  input  1  serial data from the chain tail.
REQ-014 rb_valid  output  1  one-cycle pulse qualifying rb_data.
REQ-015 rb_data  output  WORD_W  captured tail bits.
REQ-016 busy  output  1  a load is in progress.
REQ-017 done  output  1  level: the last load completed.

Function
REQ-018 The FSM SHALL have exactly four states: IDLE, LOAD, SHIFT and DONE.
REQ-019 IDLE: start=1 -> LOAD; clears the bit counter and done.
REQ-020 LOAD: s_ready=1 and chain_clk_en=0; on s_valid&&s_ready, latch s_data into the shift buffer and go to SHIFT.
REQ-021 SHIFT, each cycle:
- chain_clk_en=1 and ccff_head=buf[0];
- buf shifts right;
- bit counter increments;
- ccff_tail is sampled on the same edge into rb bit position (word bit index).
REQ-022 SHIFT exit: when the counter reaches CHAIN_LEN -> DONE; else after WORD_W bits of the current word -> LOAD.
REQ-023 Partial last word: when CHAIN_LEN is not a multiple of WORD_W, unused upper bits of the last word are discarded and never shifted.
REQ-024 Word count: exactly ceil(CHAIN_LEN/WORD_W) words SHALL be accepted per load.
REQ-025 Readback: rb_data[k] holds the k-th tail bit of the current word and unfilled bits are 0; rb_valid pulses on the cycle after a word's last bit, including the final partial word.
REQ-026 Bubbles: when s_valid=0 in LOAD, chain_clk_en stays 0 and the chain holds; there is no timeout.
REQ-027 DONE: done=1, busy=0 and chain_clk_en=0; start -> LOAD and clears done.
REQ-028 busy=1 in LOAD and SHIFT only.
REQ-029 start received in LOAD or SHIFT SHALL be ignored.
REQ-030 abort in LOAD or SHIFT: next state IDLE, chain_clk_en=0 from the next cycle, done stays 0, no rb_valid; partial chain contents are left as-is.
REQ-031 abort takes priority over start and over s_valid in the same cycle.
REQ-032 ccff_head SHALL be registered and glitch-free; chain_clk_en SHALL be registered.

Reset
REQ-033 prog_reset_n=0 SHALL immediately force:
- state IDLE;
- s_ready, chain_clk_en, ccff_head, rb_valid, busy and done to 0;
- rb_data, buffer and counter to 0.
REQ-034 Reset asserted mid-load SHALL abandon the load with no further chain_clk_en pulse; reset release alone SHALL NOT start a load.

Verification
REQ-035 Full load, default parameters, s_valid held high, words 0xA5, 0x3C, 0xF0:
- 24 chain_clk_en cycles in three runs of 8, each preceded by one LOAD cycle;
- ccff_head sequence 1,0,1,0,0,1,0,1 then 0,0,1,1,1,1,0,0 then 0,0,0,0,1,1,1,1;
- done=1 after the 24th bit.
REQ-036 Readback with a 24-stage shift model between ccff_head and ccff_tail:
- first load of 0xA5, 0x3C, 0xF0;
- second load of 0x00, 0x00, 0x00;
- required rb_data 0xA5, 0x3C, 0xF0 on the three rb_valid pulses of the second load.
REQ-037 Stall: s_valid=0 for 5 cycles before word 2 -> chain_clk_en=0 for those 5 cycles, total enabled cycles still 24, head sequence unchanged.
REQ-038 CHAIN_LEN=20, WORD_W=8:
- exactly 3 words accepted;
- last run is 4 bits, upper nibble dropped;
- third rb_data has bits [7:4]=0.
REQ-039 Abort after 10 shifted bits -> IDLE next cycle, busy=0, done=0, no further chain_clk_en; a following start performs a clean 24-bit load.
REQ-040 Reset pulse at bit 12 -> all outputs 0 asynchronously; start is ignored while held in reset.
